fetch_mem_arbiter: RTL and testbench

Shares one single-port, variable-latency memory between the fetch stage (instruction reads) and the memory stage (loads/stores). It sits between the pipeline and the memory. It drives `f_stall` back to fetch and `m_stall` to the memory stage. It also discards in-flight instruction responses that a taken branch or jump (`f_redirect`, i.e. `e_pc_src`) has made stale. At most one memory transaction is outstanding at a time.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/fetch_mem_arbiter.sv | 119 +++++++++++
 tb/tb_fetch_mem_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/memory-stage arbiter: FSM states, the captured
// memory request and the all-ones byte-enable constant.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 32;
  localparam int ARB_DATA_W = 32;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  localparam logic [ARB_BE_W-1:0] BE_ALL = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_I_REQ,
    ST_I_WAIT,
    ST_D_REQ,
    ST_D_WAIT
  } arb_state_t;

  // The request is captured once at issue and held untouched until the next issue
  typedef struct packed {
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
    logic [ARB_BE_W-1:0]   be;
  } mem_req_t;

endpackage

// File: rtl/fetch_mem_arbiter.sv
// Arbitrates one single-port, variable-latency memory between instruction fetch
// and the memory stage, dropping fetch responses made stale by a redirect.
module fetch_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_W,
  parameter int DATA_WIDTH = ARB_DATA_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    f_req,
  input  logic [ADDR_WIDTH-1:0]   f_addr,
  input  logic                    f_redirect,
  output logic                    f_stall,
  output logic [DATA_WIDTH-1:0]   f_instr,
  output logic                    f_instr_valid,
  input  logic                    m_req,
  input  logic                    m_we,
  input  logic [ADDR_WIDTH-1:0]   m_addr,
  input  logic [DATA_WIDTH-1:0]   m_wdata,
  input  logic [DATA_WIDTH/8-1:0] m_be,
  output logic                    m_stall,
  output logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    m_done,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  arb_state_t state, next_state;
  mem_req_t   req_q;
  logic       flush;

  assign mem_we    = req_q.we;
  assign mem_addr  = req_q.addr;
  assign mem_wdata = req_q.wdata;
  assign mem_be    = req_q.be;

  // A requester whose pulse is high this cycle has not advanced its address yet
  always_comb begin
    next_state = state;
    f_stall    = f_req & ~f_instr_valid;
    m_stall    = m_req & ~m_done;
    case (state)
      ST_IDLE: begin
        if (m_req && !m_done) begin
          next_state = ST_D_REQ;
        end else if (f_req && !f_instr_valid && !f_redirect) begin
          next_state = ST_I_REQ;
        end
      end
      ST_I_REQ:  if (mem_gnt)    next_state = ST_I_WAIT;
      ST_D_REQ:  if (mem_gnt)    next_state = ST_D_WAIT;
      ST_I_WAIT: if (mem_rvalid) next_state = ST_IDLE;
      ST_D_WAIT: if (mem_rvalid) next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      flush         <= 1'b0;
      req_q         <= '0;
      mem_req       <= 1'b0;
      f_instr       <= '0;
      f_instr_valid <= 1'b0;
      m_rdata       <= '0;
      m_done        <= 1'b0;
    end else begin
      state         <= next_state;
      f_instr_valid <= 1'b0;
      m_done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (next_state == ST_D_REQ) begin
            req_q   <= '{we: m_we, addr: m_addr, wdata: m_wdata, be: m_be};
            mem_req <= 1'b1;
          end else if (next_state == ST_I_REQ) begin
            req_q   <= '{we: 1'b0, addr: f_addr, wdata: '0, be: BE_ALL};
            mem_req <= 1'b1;
          end
        end
        ST_I_REQ: begin
          if (mem_gnt)    mem_req <= 1'b0;
          if (f_redirect) flush   <= 1'b1;
        end
        ST_D_REQ: begin
          if (mem_gnt) mem_req <= 1'b0;
        end
        // A redirect in the response cycle itself discards the word directly
        ST_I_WAIT: begin
          if (mem_rvalid) begin
            if (!flush && !f_redirect) begin
              f_instr       <= mem_rdata;
              f_instr_valid <= 1'b1;
            end
            flush <= 1'b0;
          end else if (f_redirect) begin
            flush <= 1'b1;
          end
        end
        ST_D_WAIT: begin
          if (mem_rvalid) begin
            if (!req_q.we) m_rdata <= mem_rdata;
            m_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// Directed bench for fetch_mem_arbiter: a memory responder fed by a queue of
// expected transactions and a transaction-level model checked every cycle.
module tb_fetch_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        f_req;
  logic [31:0] f_addr;
  logic        f_redirect;
  logic        f_stall;
  logic [31:0] f_instr;
  logic        f_instr_valid;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  logic        m_stall;
  logic [31:0] m_rdata;
  logic        m_done;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  fetch_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_redirect(f_redirect),
    .f_stall(f_stall), .f_instr(f_instr), .f_instr_valid(f_instr_valid),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_stall(m_stall), .m_rdata(m_rdata), .m_done(m_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_fetch;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          gnt_delay;
    int          rsp_delay;
    logic [31:0] rdata;
  } xact_t;

  typedef enum int {P_IDLE, P_GNT, P_ACK, P_RSP} phase_t;

  xact_t       exp_reqs[$];
  xact_t       cur;
  phase_t      phase = P_IDLE;
  int          cnt = 0;
  bit          outstanding = 1'b0;
  bit          flush_seen = 1'b0;
  bit          exp_f_valid = 1'b0;
  bit          exp_m_done = 1'b0;
  logic [31:0] exp_f_instr = '0;
  logic [31:0] exp_m_rdata = '0;
  int          total = 0;
  int          bad = 0;

  function automatic xact_t make_xact(input bit is_fetch, input bit we, input logic [31:0] addr,
                                      input logic [31:0] wdata, input logic [3:0] be,
                                      input int gnt_delay, input int rsp_delay,
                                      input logic [31:0] rdata);
    xact_t x;
    x.is_fetch = is_fetch; x.we = we; x.addr = addr; x.wdata = wdata; x.be = be;
    x.gnt_delay = gnt_delay; x.rsp_delay = rsp_delay; x.rdata = rdata;
    return x;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input bit fr, input logic [31:0] fa, input bit frd,
                                input bit mr, input bit mw, input logic [31:0] ma,
                                input logic [31:0] md, input logic [3:0] mb);
    @(posedge clk);
    #1;
    f_req = fr; f_addr = fa; f_redirect = frd;
    m_req = mr; m_we = mw; m_addr = ma; m_wdata = md; m_be = mb;
  endtask

  // Reset aborts any outstanding access; the responder is left running on purpose
  task automatic do_reset();
    reset       = 1'b1;
    outstanding = 1'b0;
    flush_seen  = 1'b0;
    exp_f_valid = 1'b0;
    exp_m_done  = 1'b0;
    exp_f_instr = '0;
    exp_m_rdata = '0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic wait_pulse(input bit fetch_side, input int budget, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      seen = fetch_side ? f_instr_valid : m_done;
    end
    if (!seen) check_output(fetch_side ? "f_instr_valid timeout" : "m_done timeout", 32'(seen), 1);
  endtask

  // Memory: grants after gnt_delay cycles of mem_req, responds rsp_delay cycles after grant
  initial begin
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '1;
    forever begin
      @(posedge clk);
      #1;
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '1;
      if (phase == P_ACK) begin
        phase = P_RSP;
        cnt   = cur.rsp_delay;
      end else if (phase == P_IDLE && mem_req) begin
        if (exp_reqs.size() == 0) begin
          check_output("unexpected mem_req", 32'(mem_req), 0);
        end else begin
          cur = exp_reqs.pop_front();
          check_output("issue mem_we", 32'(mem_we), 32'(cur.we));
          check_output("issue mem_addr", mem_addr, cur.addr);
          check_output("issue mem_be", 32'(mem_be), 32'(cur.be));
          if (!cur.is_fetch) check_output("issue mem_wdata", mem_wdata, cur.wdata);
          phase       = P_GNT;
          cnt         = cur.gnt_delay;
          outstanding = 1'b1;
        end
      end
      if (phase == P_GNT) begin
        if (cnt == 0) begin
          mem_gnt = 1'b1;
          phase   = P_ACK;
        end else begin
          cnt--;
        end
      end else if (phase == P_RSP) begin
        cnt--;
        if (cnt <= 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = cur.rdata;
          phase      = P_IDLE;
        end
      end
    end
  end

  // Model: a fetch response is delivered unless a redirect was seen while it was outstanding
  initial begin
    forever begin
      @(posedge clk);
      exp_f_valid = 1'b0;
      exp_m_done  = 1'b0;
      if (!reset && outstanding) begin
        if (mem_rvalid) begin
          outstanding = 1'b0;
          if (cur.is_fetch) begin
            if (!flush_seen && !f_redirect) begin
              exp_f_valid = 1'b1;
              exp_f_instr = mem_rdata;
            end
            flush_seen = 1'b0;
          end else begin
            exp_m_done = 1'b1;
            if (!cur.we) exp_m_rdata = mem_rdata;
          end
        end else if (cur.is_fetch && f_redirect) begin
          flush_seen = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check_output("f_instr_valid", 32'(f_instr_valid), 32'(exp_f_valid));
      check_output("f_instr", f_instr, exp_f_instr);
      check_output("m_done", 32'(m_done), 32'(exp_m_done));
      check_output("m_rdata", m_rdata, exp_m_rdata);
      check_output("f_stall", 32'(f_stall), 32'(f_req & ~exp_f_valid));
      check_output("m_stall", 32'(m_stall), 32'(m_req & ~exp_m_done));
      check_output("mem_req", 32'(mem_req), 32'(phase == P_GNT || phase == P_ACK));
      if (phase == P_GNT || phase == P_ACK) begin
        check_output("held mem_we", 32'(mem_we), 32'(cur.we));
        check_output("held mem_addr", mem_addr, cur.addr);
        check_output("held mem_be", 32'(mem_be), 32'(cur.be));
        if (!cur.is_fetch) check_output("held mem_wdata", mem_wdata, cur.wdata);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    f_req = 0; f_addr = '0; f_redirect = 0;
    m_req = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_be = '0;
    do_reset();
    @(negedge clk);
    check_output("reset mem_req", 32'(mem_req), 0);
    check_output("reset mem_addr", mem_addr, 0);
    check_output("reset f_instr", f_instr, 0);
    check_output("reset m_done", 32'(m_done), 0);

    $display("[TB] fetch only");
    exp_reqs.push_back(make_xact(1, 0, 32'h0, '0, 4'hF, 0, 1, 32'h00500093));
    exp_reqs.push_back(make_xact(1, 0, 32'h4, '0, 4'hF, 0, 1, 32'h00A00113));
    apply_stimulus(1, 32'h0, 0, 0, 0, '0, '0, '0);
    wait_pulse(1, 20, n);
    check_output("fetch latency", n, 4);
    check_output("first f_instr", f_instr, 32'h00500093);
    check_output("f_stall in pulse", 32'(f_stall), 0);
    apply_stimulus(1, 32'h4, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_output("no issue in pulse", 32'(mem_req), 0);
    @(negedge clk);
    check_output("next fetch issued", 32'(mem_req), 1);
    check_output("next fetch addr", mem_addr, 32'h4);
    wait_pulse(1, 20, n);
    check_output("second f_instr", f_instr, 32'h00A00113);
    apply_stimulus(0, 32'h4, 0, 0, 0, '0, '0, '0);

    $display("[TB] tie, data first");
    exp_reqs.push_back(make_xact(0, 0, 32'h100, '0, 4'hF, 0, 1, 32'hDEADBEEF));
    exp_reqs.push_back(make_xact(1, 0, 32'h8, '0, 4'hF, 1, 2, 32'h00000013));
    apply_stimulus(1, 32'h8, 0, 1, 0, 32'h100, '0, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check_output("tie winner addr", mem_addr, 32'h100);
    check_output("tie f_stall", 32'(f_stall), 1);
    wait_pulse(0, 20, n);
    check_output("load m_rdata", m_rdata, 32'hDEADBEEF);
    check_output("f_stall at m_done", 32'(f_stall), 1);
    apply_stimulus(1, 32'h8, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    check_output("fetch after data", 32'(mem_req), 1);
    check_output("fetch after data addr", mem_addr, 32'h8);
    wait_pulse(1, 20, n);
    check_output("tie f_instr", f_instr, 32'h00000013);
    apply_stimulus(0, 32'h8, 0, 0, 0, '0, '0, '0);

    $display("[TB] redirect in flight");
    exp_reqs.push_back(make_xact(1, 0, 32'h8, '0, 4'hF, 0, 3, 32'h12345678));
    exp_reqs.push_back(make_xact(1, 0, 32'h40, '0, 4'hF, 0, 1, 32'h0000006F));
    apply_stimulus(1, 32'h8, 0, 0, 0, '0, '0, '0);
    apply_stimulus(1, 32'h8, 0, 0, 0, '0, '0, '0);
    apply_stimulus(1, 32'h40, 1, 0, 0, '0, '0, '0);
    apply_stimulus(1, 32'h40, 0, 0, 0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_output("dropped f_instr_valid", 32'(f_instr_valid), 0);
    check_output("kept f_instr", f_instr, 32'h00000013);
    @(negedge clk);
    check_output("new pc issued", 32'(mem_req), 1);
    check_output("new pc addr", mem_addr, 32'h40);
    wait_pulse(1, 20, n);
    check_output("redirect f_instr", f_instr, 32'h0000006F);
    apply_stimulus(0, 32'h40, 0, 0, 0, '0, '0, '0);

    $display("[TB] store with slow grant");
    exp_reqs.push_back(make_xact(0, 1, 32'h200, 32'hA5A5A5A5, 4'b0011, 3, 2, 32'hBAADF00D));
    apply_stimulus(0, 32'h40, 0, 1, 1, 32'h200, 32'hA5A5A5A5, 4'b0011);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("store mem_req held", 32'(mem_req), 1);
      check_output("store mem_wdata", mem_wdata, 32'hA5A5A5A5);
      check_output("store mem_be", 32'(mem_be), 32'h3);
    end
    wait_pulse(0, 20, n);
    check_output("store m_rdata kept", m_rdata, 32'hDEADBEEF);
    check_output("store m_stall", 32'(m_stall), 0);
    apply_stimulus(0, 32'h40, 0, 0, 0, '0, '0, '0);

    $display("[TB] reset in D_WAIT");
    exp_reqs.push_back(make_xact(0, 0, 32'h300, '0, 4'hF, 0, 4, 32'h11112222));
    apply_stimulus(0, 32'h40, 0, 1, 0, 32'h300, '0, 4'hF);
    apply_stimulus(0, 32'h40, 0, 1, 0, 32'h300, '0, 4'hF);
    apply_stimulus(0, 32'h40, 0, 0, 0, '0, '0, '0);
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("late rsp m_done", 32'(m_done), 0);
      check_output("after reset m_rdata", m_rdata, 0);
      check_output("after reset mem_addr", mem_addr, 0);
      check_output("after reset mem_wdata", mem_wdata, 0);
      check_output("after reset mem_be", 32'(mem_be), 0);
    end
    check_output("requests left", exp_reqs.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
